// File: rtl/fwd_hazard_tracker.sv
// Shadow scoreboard of in-flight instructions (EX .. EX+DEPTH) producing operand and
// flag forwarding selects plus the load-use stall for the instruction sitting in ID.
module fwd_hazard_tracker #(
    parameter int unsigned AW       = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [NUM_SRC*AW-1:0]    id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_load,
    input  logic                     id_setflags,
    input  logic                     id_useflags,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     fwd_flags,
    output logic [SEL_W-1:0]         flag_sel,
    output logic                     stall
);

    typedef struct packed {
        logic                  valid;
        logic [AW-1:0]         rd;
        logic                  wr;
        logic                  ld;
        logic                  setf;
        logic                  usef;
        logic [NUM_SRC*AW-1:0] src;
        logic [NUM_SRC-1:0]    src_used;
    } entry_t;

    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    entry_t sb_q [DEPTH+1];
    entry_t ent0_d;
    logic   load_hz;
    logic   flag_hz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            sb_q[0] <= ent0_d;
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    // Flush outranks stall: either way EX receives a bubble.
    always_comb begin
        ent0_d = '0;
        if (id_valid && !stall && !flush) begin
            ent0_d.valid    = 1'b1;
            ent0_d.rd       = id_rd;
            ent0_d.wr       = id_regwrite;
            ent0_d.ld       = id_load;
            ent0_d.setf     = id_setflags;
            ent0_d.usef     = id_useflags;
            ent0_d.src      = id_src;
            ent0_d.src_used = id_src_used;
        end
    end

    always_comb begin
        load_hz = 1'b0;
        if (sb_q[0].valid && sb_q[0].wr && sb_q[0].ld && (sb_q[0].rd != ZR)) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (id_valid && id_src_used[k] && (id_src[k*AW +: AW] == sb_q[0].rd)) begin
                    load_hz = 1'b1;
                end
            end
        end
        flag_hz = id_useflags && sb_q[0].valid && sb_q[0].setf && sb_q[0].ld;
        stall   = load_hz || flag_hz;
    end

    // Scan oldest to newest so the nearest producer overwrites older ones.
    always_comb begin
        fwd_sel = '0;
        if (sb_q[0].valid) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                for (int unsigned n = 0; n < DEPTH; n++) begin
                    if (sb_q[DEPTH-n].valid && sb_q[DEPTH-n].wr && (sb_q[DEPTH-n].rd != ZR) &&
                        sb_q[0].src_used[k] && (sb_q[DEPTH-n].rd == sb_q[0].src[k*AW +: AW])) begin
                        fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(DEPTH - n);
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_flags = 1'b0;
        flag_sel  = '0;
        if (sb_q[0].valid && sb_q[0].usef) begin
            for (int unsigned n = 0; n < DEPTH; n++) begin
                if (sb_q[DEPTH-n].valid && sb_q[DEPTH-n].setf) begin
                    fwd_flags = 1'b1;
                    flag_sel  = SEL_W'(DEPTH - n);
                end
            end
        end
    end

endmodule

// File: doc/fwd_hazard_tracker.md
Name: fwd_hazard_tracker

Overview:
- Parametrised successor to the pipeline forwarding logic. It keeps its own shadow scoreboard of in-flight instructions from EX through the last writeback-capable stage.
- From that scoreboard it generates per-operand forwarding selects, flag forwarding, and load-use stall.
- It sits beside the ID/EX pipeline register and is fed decoded fields from ID, so the datapath no longer passes raw opcodes to it.
- Generalised in source-operand count, forwarding depth and register-file size. Adds load-use stall, flush and immediate masking.

Parameters:
- AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 2, forwarding stages after EX (1=MEM, 2=WB, ...).
- ZERO_REG, 31, register index never forwarded and never matched.
- SEL_W, $clog2(DEPTH+1), derived width of a forwarding select.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*AW  source register indices; operand k occupies [k*AW +: AW].
- id_src_used  in  NUM_SRC  operand k actually reads the register file (0 for immediates and unused fields).
- id_rd  in  AW  destination register.
- id_regwrite  in  1  instruction writes id_rd.
- id_load  in  1  result is available only after MEM.
- id_setflags  in  1  instruction writes NZCV (ADDS/SUBS).
- id_useflags  in  1  instruction reads NZCV (B.cond).
- flush  in  1  kill the ID instruction; EX receives a bubble.
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register-file value; j = result of stage j.
- fwd_flags  out  1  EX flag consumer must take flags from stage flag_sel.
- flag_sel  out  SEL_W  stage supplying the newest flags; 0 when fwd_flags=0.
- stall  out  1  load-use hazard: hold PC and IF/ID, inject bubble into EX.

Behaviour:
- Scoreboard has DEPTH+1 entries, index 0=EX .. DEPTH.
- Each entry holds: valid, rd, wr, ld, setf, usef, src[NUM_SRC], src_used.
- Every rising clk, entry i moves to entry i+1 (i=0..DEPTH-1). Entry DEPTH is discarded. Downstream stages never stall.
- Entry 0 loads the ID fields when id_valid=1, stall=0 and flush=0. Otherwise entry 0 loads a bubble: valid=0, all flags 0.
- Flush and stall in the same cycle: bubble; flush dominates.
- reset low: all entries invalid immediately, asynchronously. All outputs are then 0 (fwd_sel=0, fwd_flags=0, flag_sel=0, stall=0). A reset mid-operation discards all tracked writes.
- "Producer" for operand k of the EX entry: stage j in 1..DEPTH with valid, wr, rd==src[k], rd!=ZERO_REG, and src_used[k]=1.
- fwd_sel[k] = smallest such j (newest value wins); 0 if none, or if entry 0 is invalid.
- Producer at stage 1 with ld=1: still reports j=1. That case cannot occur legally because stall prevents it; the bench asserts it never happens.
- stall = 1 when entry 0 is valid with wr=1, ld=1, rd!=ZERO_REG, and some operand k of ID has id_valid, id_src_used[k] and id_src[k]==entry0.rd.
- stall is also 1 when id_useflags=1 and entry 0 is valid with setf=1 and ld=1. This is reserved: setf with ld is illegal today but is kept for generality.
- stall is combinational from the scoreboard and ID inputs. Latency: the same cycle. It lasts exactly one cycle per hazard, because the next cycle entry 0 is a bubble.
- Flags: if entry 0 is valid with usef=1, fwd_flags=1 and flag_sel = smallest j in 1..DEPTH with valid and setf. If no such stage exists, fwd_flags=0 and flag_sel=0 (architectural flags are used).
  - This replaces the old unconditional "any prior ADDS/SUBS" forwarding.
- Setter and consumer in the same instruction: a consumer never sees its own setf, since only stages >=1 are searched.
- All outputs are combinational from flops plus ID inputs. No output depends on the forwarded data values.
- ZERO_REG as a destination never forwards and never stalls, even with wr=1.
- Duplicate sources (src0==src1) each get an independent, identical select.

Test Plan:
- Back-to-back ALU dependency: ADD X1 then SUB X2,X1,X3 → in SUB's EX cycle fwd_sel[0]=1, fwd_sel[1]=0, stall never asserted.
- Distance-2 and shadowing: ADD X1; ADD X1; NOP; ORR uses X1 → sel=2 for the ORR (second writer, newest). With the NOP removed → sel=1.
- Load-use: LDUR X4 then ADD X5,X4,X4 → stall=1 for exactly 1 cycle. The next cycle EX is a bubble (all sels 0). Then ADD in EX with fwd_sel={2,2}.
- Zero register / immediate: ADD X31 then ADD X6,X31,X31 → sels 0. ADDI with id_src_used[1]=0 matching an X-reg in MEM → fwd_sel[1]=0.
- Flags: SUBS; NOP; B.LT → in B.LT's EX cycle fwd_flags=1, flag_sel=2. ADD (no S) then B.LT with no setter in flight → fwd_flags=0.
- Flush and reset: assert flush with a hazard-producing LDUR in ID → entry 0 is a bubble, no stall the next cycle. Drop reset low mid-stream with sels non-zero → all outputs 0 before the next clk edge, and they stay 0 for DEPTH+1 cycles after release until real instructions arrive.
